uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised next-generation UART core: configurable data width, parity, stop bits and bit timing.
- Valid/ready streaming interfaces replace the single-cycle transmit strobe and received pulse.
- Adds an RX FIFO with per-entry error flags, plus sticky overrun and combined irq/busy outputs.
- Instantiated directly by system wrappers; one clock domain.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit; legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits (1 or 2); RX checks only the first.
- RX_FIFO_DEPTH, 4, RX FIFO entries; power of two, legal range 2..64.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  serial in, asynchronous to clk
- tx  output  1  serial out, idle high
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  transmitter can accept a word
- tx_data  input  DATA_BITS  word to send, LSB first on the line
- rx_valid  output  1  RX FIFO not empty
- rx_ready  input  1  consumer pops the head entry
- rx_data  output  DATA_BITS  head entry data
- rx_parity_err  output  1  head entry had bad parity; always 0 when PARITY=0
- rx_frame_err  output  1  head entry's stop bit sampled low
- rx_overrun  output  1  sticky: a frame was dropped because the FIFO was full
- busy  output  1  TX not idle, or RX not idle
- irq  output  1  rx_valid | rx_overrun (level)

Behaviour:
- Reset, synchronous, applied on the clk edge with rst=1: tx=1, tx_ready=1, rx_valid=0, rx_data=0, both error flags 0, rx_overrun=0, busy=0. FIFO is emptied and both FSMs go to IDLE.
- Reset mid-frame aborts the frame; tx returns high on the next edge.
- TX FSM states: IDLE, START, DATA, PAR, STOP. tx_ready=1 only in IDLE.
  - Handshake: word accepted on an edge with tx_valid & tx_ready; tx_data is latched.
  - Cycle after accept: tx=0 (START). Every state holds the line for exactly CLKS_PER_BIT cycles.
  - DATA sends DATA_BITS bits, LSB first. PAR (skipped when PARITY=0) sends even: XOR of the data bits; odd: its inverse. STOP drives 1 for STOP_BITS bit times.
  - Frame length F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT. If accepted at edge N, tx_ready rises after edge N+F.
  - Back-to-back: a word held valid is accepted on the first tx_ready cycle. There is no idle gap beyond the stop bits.
- RX front end: rx passes a 2-flop synchroniser (rx_s); all RX timing is relative to rx_s.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on rx_s=0.
  - START: re-sample after CLKS_PER_BIT/2 cycles (integer divide). If 1, false start: return to IDLE, push nothing. If 0, go to DATA.
  - Remaining bits are sampled every CLKS_PER_BIT cycles from the start-bit midpoint, shifting right into DATA_BITS.
  - PAR computes the parity error. STOP samples the first stop bit; frame_err = (sample==0).
  - After the STOP sample: push {parity_err, frame_err, data}, return to IDLE (ready for the next falling edge immediately; the second stop bit is not awaited).
- RX FIFO: RX_FIFO_DEPTH entries, each DATA_BITS+2 wide, wrap-around pointers, count width clog2(DEPTH)+1. Outputs are combinational from the head entry.
  - Pop on rx_valid & rx_ready; rx_ready while empty is ignored.
  - Push into a full FIFO: the frame is dropped and rx_overrun is set.
  - Simultaneous push and pop when full: the pop frees an entry, so the push succeeds and no overrun occurs. Simultaneous push and pop when empty: the push is stored, rx_valid rises next cycle.
  - rx_overrun clears on the first pop after it was set. If a drop and a pop coincide, the set wins.
- busy = (TX state != IDLE) | (RX state != IDLE).

Optional Feature:
- Macro: UART_CORE_PARAM_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the RX synchroniser input is tx instead of rx, and the external tx pin is forced to 1. loopback is changed only while busy=0; behaviour otherwise is undefined.
- Not defined: port absent, RX always uses rx, no extra logic.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, RX_FIFO_DEPTH=4 unless stated):
- TX 0xA5 accepted at edge N -> tx per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; tx_ready=0 for exactly 40 cycles and rises after edge N+40.
- Drive rx with frame 0x3C -> rx_valid=1 with rx_data=0x3C, both error flags 0; pop with rx_ready=1 -> rx_valid=0 next cycle.
- rx low for 1 cycle only (glitch) -> no push, rx_valid stays 0, RX returns to IDLE.
- PARITY=1, rx frame 0x01 with parity bit 0 -> rx_parity_err=1; frame with stop bit 0 -> rx_frame_err=1.
- 5 frames, no pops -> first 4 stored in order, 5th dropped, rx_overrun=1, irq=1; one pop -> rx_overrun=0, 3 entries remain.
- With UART_CORE_PARAM_LOOPBACK_EN, loopback=1, send 0x5A -> rx_data=0x5A, external tx held 1 throughout.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART with a valid/ready transmitter, a 2-flop
// synchronised receiver and an RX FIFO carrying per-entry parity/frame flags.
// Optional feature: define UART_CORE_PARAM_LOOPBACK_EN to add the loopback input,
// which routes tx into the receiver and parks the external tx pin high.
//
// state   | meaning (shared by TX and RX FSMs)
// IDLE    | line idle; TX accepts a word, RX waits for rx_s low
// START   | start bit (TX drives 0; RX waits to the start-bit midpoint)
// DATA    | DATA_BITS data bits, LSB first
// PAR     | parity bit (only when PARITY != 0)
// STOP    | stop bit(s); RX samples the first one and pushes the frame
module uart_core_param #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 busy,
`ifdef UART_CORE_PARAM_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 irq
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY == 2);
  localparam bit   PAR_EN  = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_state, tx_state_nx;
  logic [CNT_W-1:0]     tx_cnt;
  logic [3:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_tick, tx_accept, tx_line;

  assign tx_tick   = (tx_cnt == '0);
  assign tx_accept = tx_valid & tx_ready;

  // TX next state, handshake and line level
  always_comb begin
    tx_state_nx = tx_state;
    tx_ready    = 1'b0;
    tx_line     = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) tx_state_nx = S_START;
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_state_nx = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick && tx_idx == DATA_LAST) tx_state_nx = PAR_EN ? S_PAR : S_STOP;
      end
      S_PAR: begin
        tx_line = tx_par;
        if (tx_tick) tx_state_nx = S_STOP;
      end
      S_STOP: if (tx_tick && tx_idx == STOP_LAST) tx_state_nx = S_IDLE;
      default: tx_state_nx = S_IDLE;
    endcase
  end

  // TX state register, bit timer, bit index and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= BIT_LOAD;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      if (tx_state == S_IDLE) begin
        tx_cnt <= BIT_LOAD;
        tx_idx <= '0;
        if (tx_accept) begin
          tx_shift <= tx_data;
          tx_par   <= (^tx_data) ^ PAR_ODD;
        end
      end else if (tx_tick) begin
        tx_cnt <= BIT_LOAD;
        if (tx_state == S_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= (tx_idx == DATA_LAST) ? 4'd0 : tx_idx + 4'd1;
        end else if (tx_state == S_STOP) begin
          tx_idx <= tx_idx + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt - CNT_W'(1);
      end
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_src, rx_m, rx_s;
  state_t               rx_state, rx_state_nx;
  logic [CNT_W-1:0]     rx_cnt;
  logic [3:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr, rx_tick, rx_push;

  assign rx_tick = (rx_cnt == '0);

  // RX next state; a frame is pushed on the first stop-bit sample
  always_comb begin
    rx_state_nx = rx_state;
    rx_push     = 1'b0;
    case (rx_state)
      S_IDLE:  if (!rx_s) rx_state_nx = S_START;
      S_START: if (rx_tick) rx_state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_idx == DATA_LAST) rx_state_nx = PAR_EN ? S_PAR : S_STOP;
      S_PAR:   if (rx_tick) rx_state_nx = S_STOP;
      S_STOP: begin
        if (rx_tick) begin
          rx_state_nx = S_IDLE;
          rx_push     = 1'b1;
        end
      end
      default: rx_state_nx = S_IDLE;
    endcase
  end

  // RX synchroniser, state register, mid-bit timer, shifter and parity check
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= HALF_LOAD;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else begin
      rx_m     <= rx_src;
      rx_s     <= rx_m;
      rx_state <= rx_state_nx;
      if (rx_state == S_IDLE) begin
        rx_cnt  <= HALF_LOAD;
        rx_idx  <= '0;
        rx_perr <= 1'b0;
      end else if (rx_tick) begin
        rx_cnt <= BIT_LOAD;
        if (rx_state == S_DATA) begin
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          rx_idx   <= rx_idx + 4'd1;
        end
        if (rx_state == S_PAR) rx_perr <= rx_s ^ (^rx_shift) ^ PAR_ODD;
      end else begin
        rx_cnt <= rx_cnt - CNT_W'(1);
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [EW-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, rx_pop, push_ok, drop;
  logic [EW-1:0] head;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign fifo_full = (fifo_cnt == (AW+1)'(RX_FIFO_DEPTH));
  assign rx_valid  = (fifo_cnt != '0);
  assign rx_pop    = rx_valid & rx_ready;
  assign push_ok   = rx_push & (~fifo_full | rx_pop);
  assign drop      = rx_push & fifo_full & ~rx_pop;
  assign head      = rx_valid ? fifo_mem[rd_ptr] : '0;
  assign {rx_parity_err, rx_frame_err, rx_data} = head;

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {rx_perr, ~rx_s, rx_shift};
  end

  // FIFO pointers, occupancy and sticky overrun (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, rx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop)        rx_overrun <= 1'b1;
      else if (rx_pop) rx_overrun <= 1'b0;
    end
  end

`ifdef UART_CORE_PARAM_LOOPBACK_EN
  assign rx_src = loopback ? tx_line : rx;
  assign tx     = loopback | tx_line;
`else
  assign rx_src = rx;
  assign tx     = tx_line;
`endif

  assign busy = (tx_state != S_IDLE) | (rx_state != S_IDLE);
  assign irq  = rx_valid | rx_overrun;

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: unit 0 uses the basic test configuration, unit 1
// exercises even parity, two stop bits and a different bit time.
module tb_uart_core_param;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  typedef bit bitq_t[$];
  typedef logic [DW+1:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] rx_in, tx_valid_in, rx_ready_in;
  logic [1:0][DW-1:0] tx_data_in;
  logic [1:0] tx_o, tx_ready_o, rx_valid_o, perr_o, ferr_o, ovr_o, busy_o, irq_o;
  logic [1:0][DW-1:0] rx_data_o;
  logic lb;

  int checks = 0;
  int failures = 0;
  ent_t mq[$];
  bit movr;

  uart_core_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .rx(rx_in[0]), .tx(tx_o[0]),
    .tx_valid(tx_valid_in[0]), .tx_ready(tx_ready_o[0]), .tx_data(tx_data_in[0]),
    .rx_valid(rx_valid_o[0]), .rx_ready(rx_ready_in[0]), .rx_data(rx_data_o[0]),
    .rx_parity_err(perr_o[0]), .rx_frame_err(ferr_o[0]), .rx_overrun(ovr_o[0]),
    .busy(busy_o[0]),
`ifdef UART_CORE_PARAM_LOOPBACK_EN
    .loopback(lb),
`endif
    .irq(irq_o[0]));

  uart_core_param #(.CLKS_PER_BIT(6), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .RX_FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .rx(rx_in[1]), .tx(tx_o[1]),
    .tx_valid(tx_valid_in[1]), .tx_ready(tx_ready_o[1]), .tx_data(tx_data_in[1]),
    .rx_valid(rx_valid_o[1]), .rx_ready(rx_ready_in[1]), .rx_data(rx_data_o[1]),
    .rx_parity_err(perr_o[1]), .rx_frame_err(ferr_o[1]), .rx_overrun(ovr_o[1]),
    .busy(busy_o[1]),
`ifdef UART_CORE_PARAM_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .irq(irq_o[1]));

  function automatic int cpb(int u);   return (u == 0) ? 4 : 6; endfunction
  function automatic int par(int u);   return (u == 0) ? 0 : 1; endfunction
  function automatic int stops(int u); return (u == 0) ? 1 : 2; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Line-level frame: start, data LSB first, optional parity, stop bit(s).
  function automatic bitq_t frame_bits(int u, logic [DW-1:0] d, bit bad_par, bit bad_stop);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (par(u) != 0) begin
      bit p = ($countones(d) % 2) == 1;
      if (par(u) == 2) p = !p;
      q.push_back(p ^ bad_par);
    end
    for (int s = 0; s < stops(u); s++) q.push_back(!(bad_stop && s == 0));
    return q;
  endfunction

  task automatic model_push(ent_t e);
    if (mq.size() == DEPTH) movr = 1'b1;
    else mq.push_back(e);
  endtask

  task automatic model_pop();
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      movr = 1'b0;
    end
  endtask

  task automatic check_rx(int u);
    chk("rx_valid", rx_valid_o[u], mq.size() != 0);
    if (mq.size() != 0) begin
      ent_t e = mq[0];
      chk("rx_data", rx_data_o[u], e[DW-1:0]);
      chk("rx_frame_err", ferr_o[u], e[DW]);
      chk("rx_parity_err", perr_o[u], e[DW+1]);
    end
    chk("rx_overrun", ovr_o[u], movr);
    chk("irq", irq_o[u], (mq.size() != 0) || movr);
  endtask

  task automatic pop(int u);
    rx_ready_in[u] = 1'b1;
    @(negedge clk);
    rx_ready_in[u] = 1'b0;
    model_pop();
  endtask

  task automatic drain(int u);
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
      check_rx(u);
      pop(u);
    end
    check_rx(u);
  endtask

  // Called on the falling edge right after the accepting edge.
  task automatic tx_expect(int u, logic [DW-1:0] d);
    bitq_t w = frame_bits(u, d, 1'b0, 1'b0);
    for (int j = 0; j < w.size() * cpb(u); j++) begin
      chk("tx_line", tx_o[u], w[j / cpb(u)]);
      chk("tx_ready_low", tx_ready_o[u], 1'b0);
      chk("tx_busy", busy_o[u], 1'b1);
      @(negedge clk);
    end
    chk("tx_ready_rise", tx_ready_o[u], 1'b1);
    chk("tx_idle_high", tx_o[u], 1'b1);
  endtask

  task automatic tx_send(int u, logic [DW-1:0] d, bit hold, logic [DW-1:0] nxt);
    chk("tx_ready_pre", tx_ready_o[u], 1'b1);
    tx_valid_in[u] = 1'b1;
    tx_data_in[u]  = d;
    @(negedge clk);
    tx_valid_in[u] = hold;
    tx_data_in[u]  = nxt;
    tx_expect(u, d);
    if (hold) begin
      @(negedge clk);
      tx_valid_in[u] = 1'b0;
      tx_expect(u, nxt);
    end
  endtask

  // pop_end raises rx_ready on the cycle the frame is pushed (unit 0 timing).
  task automatic rx_send(int u, logic [DW-1:0] d, bit bad_par, bit bad_stop, bit pop_end, int gap);
    bitq_t w = frame_bits(u, d, bad_par, bad_stop);
    foreach (w[k]) begin
      rx_in[u] = w[k];
      repeat (cpb(u)) @(negedge clk);
    end
    rx_in[u] = 1'b1;
    if (pop_end) pop(u);
    model_push(ent_t'({bad_par && (par(u) != 0), bad_stop, d}));
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 2'b11;
    tx_valid_in = 2'b00;
    rx_ready_in = 2'b00;
    tx_data_in = '0;
    lb = 1'b0;
    movr = 1'b0;
    repeat (3) @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      chk("rst_tx", tx_o[u], 1'b1);
      chk("rst_tx_ready", tx_ready_o[u], 1'b1);
      chk("rst_rx_valid", rx_valid_o[u], 1'b0);
      chk("rst_rx_data", rx_data_o[u], '0);
      chk("rst_perr", perr_o[u], 1'b0);
      chk("rst_ferr", ferr_o[u], 1'b0);
      chk("rst_overrun", ovr_o[u], 1'b0);
      chk("rst_busy", busy_o[u], 1'b0);
      chk("rst_irq", irq_o[u], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    tx_send(0, 8'hA5, 1'b0, '0);
    tx_send(0, DW'($urandom), 1'b1, DW'($urandom));
    tx_send(1, 8'h01, 1'b0, '0);
    tx_send(1, DW'($urandom), 1'b1, DW'($urandom));

    rx_send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 2);
    check_rx(0);
    pop(0);
    check_rx(0);

    rx_in[0] = 1'b0;
    @(negedge clk);
    rx_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy", busy_o[0], 1'b1);
    repeat (5) @(negedge clk);
    chk("glitch_idle", busy_o[0], 1'b0);
    check_rx(0);

    rx_send(1, 8'h01, 1'b1, 1'b0, 1'b0, 2 * cpb(1));
    check_rx(1);
    rx_send(1, DW'($urandom), 1'b0, 1'b1, 1'b0, 3 * cpb(1));
    check_rx(1);
    rx_send(1, DW'($urandom), 1'b0, 1'b0, 1'b0, 2 * cpb(1));
    drain(1);
    chk("rx1_idle", busy_o[1], 1'b0);

    for (int i = 0; i < 5; i++) begin
      rx_send(0, DW'($urandom), 1'b0, 1'b0, 1'b0, 2);
      check_rx(0);
    end
    chk("overrun_set", ovr_o[0], 1'b1);
    pop(0);
    check_rx(0);
    chk("entries_left", mq.size(), 3);
    rx_send(0, DW'($urandom), 1'b0, 1'b0, 1'b0, 2);
    check_rx(0);
    rx_send(0, DW'($urandom), 1'b0, 1'b0, 1'b1, 2);
    check_rx(0);
    drain(0);
    rx_send(0, DW'($urandom), 1'b0, 1'b0, 1'b1, 2);
    check_rx(0);
    drain(0);

    rx_send(0, DW'($urandom), 1'b0, 1'b0, 1'b0, 2);
    check_rx(0);
    tx_valid_in[0] = 1'b1;
    tx_data_in[0]  = DW'($urandom);
    @(negedge clk);
    tx_valid_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx_o[0], 1'b1);
    chk("midrst_tx_ready", tx_ready_o[0], 1'b1);
    chk("midrst_busy", busy_o[0], 1'b0);
    chk("midrst_rx_valid", rx_valid_o[0], 1'b0);
    rst = 1'b0;
    mq.delete();
    movr = 1'b0;
    @(negedge clk);

`ifdef UART_CORE_PARAM_LOOPBACK_EN
    lb = 1'b1;
    @(negedge clk);
    tx_valid_in[0] = 1'b1;
    tx_data_in[0]  = 8'h5A;
    @(negedge clk);
    tx_valid_in[0] = 1'b0;
    for (int j = 0; j < 10 * cpb(0); j++) begin
      chk("lb_tx_pin", tx_o[0], 1'b1);
      @(negedge clk);
    end
    repeat (2 * cpb(0)) @(negedge clk);
    model_push(ent_t'({2'b00, 8'h5A}));
    check_rx(0);
    drain(0);
    lb = 1'b0;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
